lieat_exu_comq: RTL and testbench
=================================

# lieat_exu_comq

Parametrised common-execution stage with a buffered result queue. It holds one issued op in an execute register and presents it to a shared combinational execute unit (ALU/BJP/CSR datapath). The result is pushed into a DEPTH-entry writeback queue, so execution is decoupled from writeback back-pressure. It sits between issue and the writeback arbiter. Unlike the single-slot stage, it also offers rd-indexed forwarding out of all queued results and supports issue-side flush.

## Interface
- XLEN, 32, data/pc width
- RGIDX_SIZE, 5, register index width
- DEPTH, 2, result queue entries; power of two, ≥2
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- com_i_valid / com_i_ready  in/out  1  issue handshake
- com_i_pc, com_i_imm, com_i_src1, com_i_src2, com_i_infobus  in  XLEN  issued op fields
- com_i_rd  in  RGIDX_SIZE  destination; com_i_rdwen  in  1  writes rd
- com_flush  in  1  kill the op in the execute register; block issue this cycle
- exe_req_valid  out  1  execute register holds an op
- exe_req_pc, exe_req_imm, exe_req_src1, exe_req_src2, exe_req_infobus  out  XLEN  registered op fields
- exe_res  in  XLEN  combinational result for the current exe_req
- com_o_valid / com_o_ready  out/in  1  writeback handshake, queue head
- com_o_pc, com_o_data  out  XLEN; com_o_rd  out  RGIDX_SIZE; com_o_wen  out  1  head entry fields
- com_o_cnt  out  $clog2(DEPTH+1)  occupied entries
- fwd_rd  in  RGIDX_SIZE  forwarding query
- fwd_hit  out  1; fwd_data  out  XLEN  forwarding response

## Operation
- Execute register (E): one valid bit plus fields. exe_req_* outputs are direct register outputs.
- push = exe_req_valid & ~com_flush & (cnt<DEPTH | pop). pop = com_o_valid & com_o_ready.
- com_i_ready = ~com_flush & (~exe_req_valid | push). An accepted op loads E.
- E valid next: com_flush → 0; else accept → 1; else push → 0; else hold.
- Push writes {pc, rdwen, rd, exe_res} at the write pointer.
- Queue: read and write pointers of $clog2(DEPTH)+1 bits. Empty when pointers are equal. Full when indexes are equal and MSBs differ. Pointers wrap modulo 2·DEPTH.
- com_o_valid = cnt≠0. Head fields are driven from the read pointer entry.
- Push and pop in the same cycle: cnt is unchanged. This is legal when the queue is full.
- Forwarding: scan from youngest to oldest. Candidates are E (data = exe_res) when exe_req_valid and not flushed, then the queue entries. fwd_hit is set on the first match with wen=1, rd=fwd_rd and rd≠0; fwd_data is that data. On a miss, fwd_data=0.
- Flush never touches queued entries. Queued entries are architecturally complete.

## Timing
- Reset: E valid 0, pointers 0, cnt 0, all entry storage 0. Therefore com_o_valid=0, com_o_* =0, exe_req_valid=0, exe_req_* =0, fwd_hit=0, fwd_data=0. com_i_ready=1 once rstn deasserts.
- Latency: op accepted at edge N. exe_req_valid from N. Pushed at edge N+1. com_o_valid from N+1, i.e. 2 edges from issue handshake to visible writeback.
- Throughput: 1 op/cycle sustained with com_o_ready=1.
- Stall: queue full with no pop → E holds, exe_req_* stable, com_i_ready=0. exe_res must stay valid while held.
- Flush in the same cycle as a would-be push: the push is suppressed and E clears at the edge.
- Asynchronous reset mid-stream discards E and all queue contents.

## Configuration
- LIEAT_COMQ_FWD_EN defined: forwarding scan is built as above.
- Undefined: fwd_hit=0 and fwd_data=0 constantly; fwd_rd is unused; no scan logic is built.

## Structure
- Shared package: XLEN and RGIDX_SIZE defaults, the INFOBUS_OP field range, and the queue-entry field layout {pc, wen, rd, data}.
- One sub-module, lieat_exu_comq_fifo: the DEPTH-entry storage with pointers, cnt, push/pop and a per-entry read-out bus for the forwarding scan. E-stage control and the forwarding mux stay in the top.

## Test plan
- Single op: pc=0x100, rd=3, rdwen=1, exe_res=0xDEAD. Required: com_o_valid rises 2 edges after accept with rd=3, data=0xDEAD, cnt=1; pop → cnt=0.
- Back-pressure, DEPTH=2: com_o_ready=0, issue 4 ops with results 1,2,3,4. Required: cnt=2, then E holds op 3 with com_i_ready=0. After releasing ready, drain order is 1,2,3,4.
- Full push+pop: queue full, E valid, com_o_ready=1. Required: push and pop in the same cycle, cnt stays 2, no bubble.
- Flush: assert com_flush with E holding rd=5, result 0x55, queue non-empty. Required: nothing pushed, queue unchanged, com_i_ready=0 in that cycle.
- Forwarding: queue holds rd=7 → 0x11 and a younger rd=7 → 0x22; E holds rd=7 → 0x33. Query fwd_rd=7 → hit, 0x33. Clear E → hit, 0x22. Query rd=0 → miss. Without LIEAT_COMQ_FWD_EN → always miss.
- Reset: assert rstn=0 mid-stream with 2 entries queued. Required: all outputs 0 immediately, cnt=0, pointers wrap correctly over >2·DEPTH subsequent ops.

Source files
------------

// File: rtl/lieat_exu_comq_pkg.sv
// Shared definitions for the common-execution stage and its result queue.
// Queue entries are packed as {pc, wen, rd, data} with data in the LSBs.
// The helper functions below give the field offsets for any XLEN/RGIDX_SIZE.
package lieat_exu_comq_pkg;

   localparam int COMQ_XLEN       = 32;
   localparam int COMQ_RGIDX_SIZE = 5;
   localparam int COMQ_DEPTH      = 2;

   // Opcode field inside the issued infobus word
   localparam int INFOBUS_OP_LSB  = 0;
   localparam int INFOBUS_OP_MSB  = 3;

   // Which producer answered a forwarding query
   typedef enum logic [1:0] {
      FWD_SRC_NONE  = 2'd0,
      FWD_SRC_QUEUE = 2'd1,
      FWD_SRC_EXE   = 2'd2
   } comq_fwd_src_e;

   // Full entry width: pc + wen + rd + data
   function automatic int comq_ent_w(input int xlen, input int rgidx);
      return 2 * xlen + rgidx + 1;
   endfunction

   // Forwarding view of an entry: {wen, rd, data}, the low part of the entry
   function automatic int comq_fwd_w(input int xlen, input int rgidx);
      return xlen + rgidx + 1;
   endfunction

   function automatic int comq_rd_lsb(input int xlen);
      return xlen;
   endfunction

   function automatic int comq_wen_bit(input int xlen, input int rgidx);
      return xlen + rgidx;
   endfunction

   function automatic int comq_pc_lsb(input int xlen, input int rgidx);
      return xlen + rgidx + 1;
   endfunction

endpackage

// File: rtl/lieat_exu_comq_fifo.sv
// DEPTH-entry result queue for lieat_exu_comq.
// Pointers carry one extra wrap bit so full and empty are distinguishable;
// DEPTH must be a power of two. The ord_o bus exposes the {wen, rd, data}
// part of every entry in age order (slot 0 = oldest) for the forwarding scan.
module lieat_exu_comq_fifo
   import lieat_exu_comq_pkg::*;
#(
   parameter  int XLEN       = COMQ_XLEN,
   parameter  int RGIDX_SIZE = COMQ_RGIDX_SIZE,
   parameter  int DEPTH      = COMQ_DEPTH,
   localparam int EW         = comq_ent_w(XLEN, RGIDX_SIZE),
   localparam int FW         = comq_fwd_w(XLEN, RGIDX_SIZE),
   localparam int IW         = $clog2(DEPTH),
   localparam int PW         = IW + 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                push_i,
   input  logic                pop_i,
   input  logic [EW-1:0]       wdata_i,
   output logic [EW-1:0]       head_o,
   output logic [PW-1:0]       cnt_o,
   output logic                full_o,
   output logic [DEPTH*FW-1:0] ord_o,
   output logic [DEPTH-1:0]    ord_vld_o
);

   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] cnt;
   logic [IW-1:0] widx, ridx;

   assign widx   = wptr_q[IW-1:0];
   assign ridx   = rptr_q[IW-1:0];
   assign cnt    = wptr_q - rptr_q;
   assign cnt_o  = cnt;
   assign full_o = (widx == ridx) && (wptr_q[PW-1] != rptr_q[PW-1]);
   assign head_o = mem_q[ridx];

   // Pointer advance; wrap modulo 2*DEPTH falls out of the PW-bit width
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_i) wptr_d = wptr_q + PW'(1);
      if (pop_i)  rptr_d = rptr_q + PW'(1);
   end

   // Pointer registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Entry storage; cleared on reset so an empty queue presents zeros
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_i) begin
         mem_q[widx] <= wdata_i;
      end
   end

   // Age-ordered read-out: slot k is the k-th oldest occupied entry
   for (genvar k = 0; k < DEPTH; k++) begin : g_ord
      logic [IW-1:0] idx;
      assign idx                 = ridx + IW'(k);
      assign ord_o[k*FW +: FW]   = mem_q[idx][FW-1:0];
      assign ord_vld_o[k]        = (PW'(k) < cnt);
   end

endmodule

// File: rtl/lieat_exu_comq.sv
// Common-execution stage: one execute register (E) feeding a shared
// combinational execute unit, with results buffered in a DEPTH-entry queue
// ahead of the writeback arbiter. Issue-side flush kills only the op in E.
// Optional feature macro: LIEAT_COMQ_FWD_EN enables the rd-indexed
// forwarding scan over E and all queued results; without it fwd_hit and
// fwd_data are tied to zero.
module lieat_exu_comq
   import lieat_exu_comq_pkg::*;
#(
   parameter int XLEN       = COMQ_XLEN,
   parameter int RGIDX_SIZE = COMQ_RGIDX_SIZE,
   parameter int DEPTH      = COMQ_DEPTH
) (
   input  logic                       clk,
   input  logic                       rstn,
   // issue side
   input  logic                       com_i_valid,
   output logic                       com_i_ready,
   input  logic [XLEN-1:0]            com_i_pc,
   input  logic [XLEN-1:0]            com_i_imm,
   input  logic [XLEN-1:0]            com_i_src1,
   input  logic [XLEN-1:0]            com_i_src2,
   input  logic [XLEN-1:0]            com_i_infobus,
   input  logic [RGIDX_SIZE-1:0]      com_i_rd,
   input  logic                       com_i_rdwen,
   input  logic                       com_flush,
   // shared execute unit
   output logic                       exe_req_valid,
   output logic [XLEN-1:0]            exe_req_pc,
   output logic [XLEN-1:0]            exe_req_imm,
   output logic [XLEN-1:0]            exe_req_src1,
   output logic [XLEN-1:0]            exe_req_src2,
   output logic [XLEN-1:0]            exe_req_infobus,
   input  logic [XLEN-1:0]            exe_res,
   // writeback side
   output logic                       com_o_valid,
   input  logic                       com_o_ready,
   output logic [XLEN-1:0]            com_o_pc,
   output logic [XLEN-1:0]            com_o_data,
   output logic [RGIDX_SIZE-1:0]      com_o_rd,
   output logic                       com_o_wen,
   output logic [$clog2(DEPTH+1)-1:0] com_o_cnt,
   // forwarding
   input  logic [RGIDX_SIZE-1:0]      fwd_rd,
   output logic                       fwd_hit,
   output logic [XLEN-1:0]            fwd_data
);

   localparam int EW      = comq_ent_w(XLEN, RGIDX_SIZE);
   localparam int FW      = comq_fwd_w(XLEN, RGIDX_SIZE);
   localparam int RD_LSB  = comq_rd_lsb(XLEN);
   localparam int WEN_BIT = comq_wen_bit(XLEN, RGIDX_SIZE);
   localparam int PC_LSB  = comq_pc_lsb(XLEN, RGIDX_SIZE);

   logic                  exe_vld_q,  exe_vld_d;
   logic [XLEN-1:0]       exe_pc_q,   exe_pc_d;
   logic [XLEN-1:0]       exe_imm_q,  exe_imm_d;
   logic [XLEN-1:0]       exe_src1_q, exe_src1_d;
   logic [XLEN-1:0]       exe_src2_q, exe_src2_d;
   logic [XLEN-1:0]       exe_info_q, exe_info_d;
   logic [RGIDX_SIZE-1:0] exe_rd_q,   exe_rd_d;
   logic                  exe_wen_q,  exe_wen_d;

   logic                  push, pop, accept, q_full;
   logic [EW-1:0]         q_wdata, q_head;
   logic [DEPTH*FW-1:0]   fwd_ord;
   logic [DEPTH-1:0]      fwd_ord_vld;

   // A full queue can still take a push when its head leaves this cycle
   assign pop         = com_o_valid & com_o_ready;
   assign push        = exe_vld_q & ~com_flush & (~q_full | pop);
   assign com_i_ready = ~com_flush & (~exe_vld_q | push);
   assign accept      = com_i_valid & com_i_ready;

   assign q_wdata     = {exe_pc_q, exe_wen_q, exe_rd_q, exe_res};

   // E-stage next state: flush wins, then a new op, then drain into the queue
   always_comb begin
      exe_vld_d  = exe_vld_q;
      exe_pc_d   = exe_pc_q;
      exe_imm_d  = exe_imm_q;
      exe_src1_d = exe_src1_q;
      exe_src2_d = exe_src2_q;
      exe_info_d = exe_info_q;
      exe_rd_d   = exe_rd_q;
      exe_wen_d  = exe_wen_q;
      if (com_flush)   exe_vld_d = 1'b0;
      else if (accept) exe_vld_d = 1'b1;
      else if (push)   exe_vld_d = 1'b0;
      if (accept) begin
         exe_pc_d   = com_i_pc;
         exe_imm_d  = com_i_imm;
         exe_src1_d = com_i_src1;
         exe_src2_d = com_i_src2;
         exe_info_d = com_i_infobus;
         exe_rd_d   = com_i_rd;
         exe_wen_d  = com_i_rdwen;
      end
   end

   // E-stage register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         exe_vld_q  <= 1'b0;
         exe_pc_q   <= '0;
         exe_imm_q  <= '0;
         exe_src1_q <= '0;
         exe_src2_q <= '0;
         exe_info_q <= '0;
         exe_rd_q   <= '0;
         exe_wen_q  <= 1'b0;
      end else begin
         exe_vld_q  <= exe_vld_d;
         exe_pc_q   <= exe_pc_d;
         exe_imm_q  <= exe_imm_d;
         exe_src1_q <= exe_src1_d;
         exe_src2_q <= exe_src2_d;
         exe_info_q <= exe_info_d;
         exe_rd_q   <= exe_rd_d;
         exe_wen_q  <= exe_wen_d;
      end
   end

   assign exe_req_valid   = exe_vld_q;
   assign exe_req_pc      = exe_pc_q;
   assign exe_req_imm     = exe_imm_q;
   assign exe_req_src1    = exe_src1_q;
   assign exe_req_src2    = exe_src2_q;
   assign exe_req_infobus = exe_info_q;

   lieat_exu_comq_fifo #(
      .XLEN       (XLEN),
      .RGIDX_SIZE (RGIDX_SIZE),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push_i    (push),
      .pop_i     (pop),
      .wdata_i   (q_wdata),
      .head_o    (q_head),
      .cnt_o     (com_o_cnt),
      .full_o    (q_full),
      .ord_o     (fwd_ord),
      .ord_vld_o (fwd_ord_vld)
   );

   assign com_o_valid = (com_o_cnt != '0);
   assign com_o_pc    = q_head[PC_LSB +: XLEN];
   assign com_o_wen   = q_head[WEN_BIT];
   assign com_o_rd    = q_head[RD_LSB +: RGIDX_SIZE];
   assign com_o_data  = q_head[XLEN-1:0];

`ifdef LIEAT_COMQ_FWD_EN
   localparam int IW = $clog2(DEPTH);

   logic [XLEN-1:0]       fq_data [DEPTH];
   logic [RGIDX_SIZE-1:0] fq_rd   [DEPTH];
   logic                  fq_wen  [DEPTH];
   comq_fwd_src_e         fwd_src;
   logic [IW-1:0]         fwd_idx;

   for (genvar k = 0; k < DEPTH; k++) begin : g_fwd_ent
      assign fq_data[k] = fwd_ord[k*FW +: XLEN];
      assign fq_rd[k]   = fwd_ord[k*FW + RD_LSB +: RGIDX_SIZE];
      assign fq_wen[k]  = fwd_ord[k*FW + WEN_BIT];
   end

   // Youngest producer wins: scan queue oldest-to-youngest so later matches override, then E
   always_comb begin
      fwd_src = FWD_SRC_NONE;
      fwd_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (fwd_ord_vld[k] && fq_wen[k] && (fq_rd[k] == fwd_rd) && (fwd_rd != '0)) begin
            fwd_src = FWD_SRC_QUEUE;
            fwd_idx = IW'(k);
         end
      end
      if (exe_vld_q && !com_flush && exe_wen_q && (exe_rd_q == fwd_rd) && (fwd_rd != '0))
         fwd_src = FWD_SRC_EXE;
   end

   // Forwarding response mux; a miss returns zero data
   always_comb begin
      fwd_hit  = (fwd_src != FWD_SRC_NONE);
      fwd_data = '0;
      unique case (fwd_src)
         FWD_SRC_EXE:   fwd_data = exe_res;
         FWD_SRC_QUEUE: fwd_data = fq_data[fwd_idx];
         default:       fwd_data = '0;
      endcase
   end
`else
   logic unused_fwd;

   assign unused_fwd = ^{fwd_rd, fwd_ord, fwd_ord_vld};
   assign fwd_hit    = 1'b0;
   assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_lieat_exu_comq.sv
// Directed bench for lieat_exu_comq with a writeback scoreboard.
// The execute unit is modelled as exe_res = src1 + src2.
module tb_lieat_exu_comq;

   localparam int XLEN  = 32;
   localparam int RG    = 5;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH + 1);
`ifdef LIEAT_COMQ_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rstn = 1'b1;
   logic            com_i_valid, com_i_ready, com_i_rdwen, com_flush;
   logic [XLEN-1:0] com_i_pc, com_i_imm, com_i_src1, com_i_src2, com_i_infobus;
   logic [RG-1:0]   com_i_rd;
   logic            exe_req_valid;
   logic [XLEN-1:0] exe_req_pc, exe_req_imm, exe_req_src1, exe_req_src2, exe_req_infobus;
   logic [XLEN-1:0] exe_res;
   logic            com_o_valid, com_o_ready, com_o_wen;
   logic [XLEN-1:0] com_o_pc, com_o_data;
   logic [RG-1:0]   com_o_rd;
   logic [CW-1:0]   com_o_cnt;
   logic [RG-1:0]   fwd_rd;
   logic            fwd_hit;
   logic [XLEN-1:0] fwd_data;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic            wen;
      logic [RG-1:0]   rd;
      logic [XLEN-1:0] data;
   } ent_t;

   ent_t sb[$];
   ent_t cur_ent;
   ent_t exp_ent;
   int   errors = 0;
   int   checks = 0;
   int   waits;
   int   stalls;
   int   n;

   assign exe_res = exe_req_src1 + exe_req_src2;

   always #5 clk = ~clk;

   lieat_exu_comq #(.XLEN(XLEN), .RGIDX_SIZE(RG), .DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn),
      .com_i_valid(com_i_valid), .com_i_ready(com_i_ready),
      .com_i_pc(com_i_pc), .com_i_imm(com_i_imm), .com_i_src1(com_i_src1),
      .com_i_src2(com_i_src2), .com_i_infobus(com_i_infobus),
      .com_i_rd(com_i_rd), .com_i_rdwen(com_i_rdwen), .com_flush(com_flush),
      .exe_req_valid(exe_req_valid), .exe_req_pc(exe_req_pc), .exe_req_imm(exe_req_imm),
      .exe_req_src1(exe_req_src1), .exe_req_src2(exe_req_src2),
      .exe_req_infobus(exe_req_infobus), .exe_res(exe_res),
      .com_o_valid(com_o_valid), .com_o_ready(com_o_ready), .com_o_pc(com_o_pc),
      .com_o_data(com_o_data), .com_o_rd(com_o_rd), .com_o_wen(com_o_wen),
      .com_o_cnt(com_o_cnt), .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
   );

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Observe handshakes just before the edge, then advance one cycle
   task automatic tick();
      #1;
      if (rstn) begin
         if (com_i_valid && com_i_ready) sb.push_back(cur_ent);
         if (com_flush && exe_req_valid && sb.size() != 0) void'(sb.pop_back());
         if (com_o_valid && com_o_ready) begin
            if (sb.size() == 0) begin
               chk("pop_unexpected", 80'(com_o_valid), 80'(0));
            end else begin
               exp_ent = sb.pop_front();
               chk("pop_head", {com_o_pc, com_o_wen, com_o_rd, com_o_data}, 80'(exp_ent));
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [XLEN-1:0] pc, input logic [RG-1:0] rd,
                           input logic wen, input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2);
      com_i_valid   = 1'b1;
      com_i_pc      = pc;
      com_i_imm     = pc ^ 32'h5A5A_0000;
      com_i_infobus = pc | 32'hC0DE_0000;
      com_i_src1    = s1;
      com_i_src2    = s2;
      com_i_rd      = rd;
      com_i_rdwen   = wen;
      cur_ent       = '{pc: pc, wen: wen, rd: rd, data: s1 + s2};
   endtask

   task automatic issue(input logic [XLEN-1:0] pc, input logic [RG-1:0] rd,
                        input logic [XLEN-1:0] s1, output int w);
      w = 0;
      drive_op(pc, rd, 1'b1, s1, 32'h0);
      #1;
      while (!com_i_ready && w < 20) begin
         tick();
         w++;
      end
      chk("issue_accept", 80'(com_i_ready), 80'(1));
      tick();
      com_i_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      com_i_valid = 0; com_i_pc = 0; com_i_imm = 0; com_i_src1 = 0; com_i_src2 = 0;
      com_i_infobus = 0; com_i_rd = 0; com_i_rdwen = 0; com_flush = 0;
      com_o_ready = 0; fwd_rd = 0; cur_ent = '0;

      // asynchronous reset state
      #2 rstn = 1'b0;
      #1;
      chk("rst_o_valid", 80'(com_o_valid), 80'(0));
      chk("rst_cnt", 80'(com_o_cnt), 80'(0));
      chk("rst_e_valid", 80'(exe_req_valid), 80'(0));
      chk("rst_o_data", 80'(com_o_data), 80'(0));
      chk("rst_o_pc", 80'(com_o_pc), 80'(0));
      chk("rst_e_pc", 80'(exe_req_pc), 80'(0));
      chk("rst_fwd_hit", 80'(fwd_hit), 80'(0));
      chk("rst_fwd_data", 80'(fwd_data), 80'(0));
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      #1;
      chk("rst_i_ready", 80'(com_i_ready), 80'(1));

      // single op: writeback visible two edges after accept
      com_o_ready = 1'b1;
      drive_op(32'h100, 5'd3, 1'b1, 32'hDE00, 32'h00AD);
      tick();
      com_i_valid = 1'b0;
      #1;
      chk("lat_e_valid", 80'(exe_req_valid), 80'(1));
      chk("lat_e_pc", 80'(exe_req_pc), 80'(32'h100));
      chk("lat_e_imm", 80'(exe_req_imm), 80'(32'h5A5A_0100));
      chk("lat_e_info", 80'(exe_req_infobus), 80'(32'hC0DE_0100));
      chk("lat_o_valid_early", 80'(com_o_valid), 80'(0));
      tick();
      chk("lat_o_valid", 80'(com_o_valid), 80'(1));
      chk("lat_cnt1", 80'(com_o_cnt), 80'(1));
      chk("lat_o_rd", 80'(com_o_rd), 80'(3));
      chk("lat_o_data", 80'(com_o_data), 80'(32'hDEAD));
      chk("lat_e_empty", 80'(exe_req_valid), 80'(0));
      tick();
      chk("lat_cnt0", 80'(com_o_cnt), 80'(0));
      chk("lat_o_valid_off", 80'(com_o_valid), 80'(0));

      // back-pressure: two queued, op3 held in E
      com_o_ready = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         drive_op(32'h200 + 32'(4 * k), 5'(k), 1'b1, 32'(k), 32'h0);
         tick();
      end
      drive_op(32'h210, 5'd4, 1'b1, 32'd4, 32'h0);
      #1;
      chk("bp_cnt_full", 80'(com_o_cnt), 80'(2));
      chk("bp_i_ready", 80'(com_i_ready), 80'(0));
      chk("bp_e_op3", 80'(exe_req_src1), 80'(3));
      tick();
      tick();
      chk("bp_e_stable", 80'(exe_req_pc), 80'(32'h20C));
      chk("bp_cnt_hold", 80'(com_o_cnt), 80'(2));
      chk("bp_head1", 80'(com_o_data), 80'(1));
      chk("bp_i_ready_hold", 80'(com_i_ready), 80'(0));

      // full queue with pop: push and pop together, no bubble
      com_o_ready = 1'b1;
      #1;
      chk("fp_i_ready", 80'(com_i_ready), 80'(1));
      tick();
      com_i_valid = 1'b0;
      #1;
      chk("fp_cnt", 80'(com_o_cnt), 80'(2));
      chk("fp_e_op4", 80'(exe_req_src1), 80'(4));
      chk("fp_e_valid", 80'(exe_req_valid), 80'(1));
      tick();
      chk("fp_cnt2", 80'(com_o_cnt), 80'(2));
      chk("fp_e_drained", 80'(exe_req_valid), 80'(0));
      tick();
      tick();
      chk("bp_drained", 80'(com_o_cnt), 80'(0));
      chk("bp_sb_empty", 80'(sb.size()), 80'(0));

      // flush: E holds rd=5/0x55, queue holds rd=2/0x44
      com_o_ready = 1'b0;
      drive_op(32'h300, 5'd2, 1'b1, 32'h44, 32'h0);
      tick();
      drive_op(32'h304, 5'd5, 1'b1, 32'h55, 32'h0);
      tick();
      drive_op(32'h308, 5'd6, 1'b1, 32'h66, 32'h0);
      com_flush = 1'b1;
      #1;
      chk("fl_i_ready", 80'(com_i_ready), 80'(0));
      chk("fl_e_valid_pre", 80'(exe_req_valid), 80'(1));
      chk("fl_e_res", 80'(exe_res), 80'(32'h55));
      tick();
      com_flush = 1'b0;
      com_i_valid = 1'b0;
      #1;
      chk("fl_e_clear", 80'(exe_req_valid), 80'(0));
      chk("fl_cnt", 80'(com_o_cnt), 80'(1));
      chk("fl_head", 80'(com_o_data), 80'(32'h44));
      tick();
      chk("fl_cnt_after", 80'(com_o_cnt), 80'(1));
      com_o_ready = 1'b1;
      tick();
      chk("fl_drained", 80'(com_o_cnt), 80'(0));

      // forwarding: queue 0x11, 0x22 and E 0x33, all rd=7
      com_o_ready = 1'b0;
      drive_op(32'h400, 5'd7, 1'b1, 32'h11, 32'h0);
      tick();
      drive_op(32'h404, 5'd7, 1'b1, 32'h22, 32'h0);
      tick();
      drive_op(32'h408, 5'd7, 1'b1, 32'h33, 32'h0);
      tick();
      com_i_valid = 1'b0;
      fwd_rd = 5'd7;
      #1;
      chk("fwd_e_hit", 80'(fwd_hit), 80'(FWD));
      chk("fwd_e_data", 80'(fwd_data), 80'(FWD ? 32'h33 : 32'h0));
      com_flush = 1'b1;
      #1;
      chk("fwd_fl_hit", 80'(fwd_hit), 80'(FWD));
      chk("fwd_fl_data", 80'(fwd_data), 80'(FWD ? 32'h22 : 32'h0));
      tick();
      com_flush = 1'b0;
      #1;
      chk("fwd_q_hit", 80'(fwd_hit), 80'(FWD));
      chk("fwd_q_data", 80'(fwd_data), 80'(FWD ? 32'h22 : 32'h0));
      fwd_rd = 5'd0;
      #1;
      chk("fwd_x0_hit", 80'(fwd_hit), 80'(0));
      chk("fwd_x0_data", 80'(fwd_data), 80'(0));
      fwd_rd = 5'd9;
      #1;
      chk("fwd_miss_hit", 80'(fwd_hit), 80'(0));

      // reset mid-stream with two queued entries and E occupied
      drive_op(32'h500, 5'd8, 1'b1, 32'h66, 32'h0);
      tick();
      com_i_valid = 1'b0;
      chk("mr_pre_cnt", 80'(com_o_cnt), 80'(2));
      rstn = 1'b0;
      #1;
      chk("mr_o_valid", 80'(com_o_valid), 80'(0));
      chk("mr_cnt", 80'(com_o_cnt), 80'(0));
      chk("mr_e_valid", 80'(exe_req_valid), 80'(0));
      chk("mr_o_data", 80'(com_o_data), 80'(0));
      chk("mr_o_pc", 80'(com_o_pc), 80'(0));
      chk("mr_o_rd", 80'(com_o_rd), 80'(0));
      chk("mr_e_src1", 80'(exe_req_src1), 80'(0));
      chk("mr_fwd_hit", 80'(fwd_hit), 80'(0));
      sb.delete();
      @(posedge clk);
      #1 rstn = 1'b1;
      #1;
      chk("mr_i_ready", 80'(com_i_ready), 80'(1));

      // pointer wrap over more than 2*DEPTH ops at full throughput
      com_o_ready = 1'b1;
      fwd_rd = 5'd0;
      stalls = 0;
      for (int k = 0; k < 7; k++) begin
         issue(32'h600 + 32'(4 * k), 5'(k + 1), 32'h1000 + 32'(k), waits);
         stalls += waits;
      end
      chk("wrap_stalls", 80'(stalls), 80'(0));
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      chk("wrap_drain_done", 80'(sb.size()), 80'(0));
      chk("wrap_cnt0", 80'(com_o_cnt), 80'(0));
      chk("wrap_o_valid", 80'(com_o_valid), 80'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
